// File: rtl/delay_pipe.sv
// +--------------------------------------------------------------------------+
// | delay_pipe: N-bit bus delay of 0..MAXD enabled cycles, runtime-set,      |
// | masked to Rval until filled. Optional flush port: DELAY_PIPE_FLUSH_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module delay_pipe #(
  parameter int   N    = 1,
  parameter int   MAXD = 16,
  parameter int   T    = 1,
  parameter logic Rval = 1'b0,
  localparam int  DW   = $clog2(MAXD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef DELAY_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          dly_wr,
  input  logic [DW-1:0] dly,
  output logic [DW-1:0] dly_cur,
  input  logic [N-1:0]  i,
  output logic [N-1:0]  o,
  output logic          o_valid
);

  localparam int            PW       = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int            TC       = (T > MAXD) ? MAXD : T;
  localparam logic [DW-1:0] c_tinit  = DW'(TC);
  localparam logic [DW-1:0] c_maxd   = DW'(MAXD);
  localparam logic [PW-1:0] c_wplast = PW'(MAXD - 1);

  logic [N-1:0]  r_mem [MAXD];
  logic [PW-1:0] r_wp;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_dly;

  logic          w_clr;
  logic [DW-1:0] w_dly_sat;
  logic [DW-1:0] w_wpx;
  logic [DW-1:0] w_rdx;
  logic [PW-1:0] w_rd;

`ifdef DELAY_PIPE_FLUSH_EN
  assign w_clr = dly_wr | flush;
`else
  assign w_clr = dly_wr;
`endif

  assign w_dly_sat = (dly > c_maxd) ? c_maxd : dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_dly  <= c_tinit;
    end else begin
      if (en) begin
        r_wp <= (r_wp == c_wplast) ? '0 : r_wp + PW'(1);
      end
      // A clear wins over counting: a write in the same cycle is not counted.
      if (w_clr) begin
        r_fill <= '0;
        if (dly_wr) begin
          r_dly <= w_dly_sat;
        end
      end else if (en && (r_fill != r_dly)) begin
        r_fill <= r_fill + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !rst) begin
      r_mem[r_wp] <= i;
    end
  end

  // Read slot is the d-th most recent write: (wp - d) mod MAXD; d=MAXD gives wp.
  always_comb begin
    w_wpx = DW'(r_wp);
    if (w_wpx >= r_dly) begin
      w_rdx = w_wpx - r_dly;
    end else begin
      w_rdx = w_wpx + c_maxd - r_dly;
    end
    w_rd = PW'(w_rdx);
  end

  assign o_valid = (r_fill == r_dly);
  assign dly_cur = r_dly;
  assign o       = (r_dly == '0) ? i : (o_valid ? r_mem[w_rd] : {N{Rval}});

endmodule

`default_nettype wire

// File: tb/tb_delay_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_delay_pipe: randomized self-checking bench for delay_pipe against a   |
// | sample-history reference model. Revision: 1.0                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_delay_pipe;

  localparam int N    = 8;
  localparam int MAXD = 16;
  localparam int T    = 4;
  localparam int DW   = $clog2(MAXD + 1);
`ifdef DELAY_PIPE_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, flush, dly_wr;
  logic [DW-1:0] dly, dly_cur;
  logic [N-1:0]  i, o;
  logic          o_valid;

  int total = 0;
  int bad   = 0;

  // Reference model: every enabled sample ever taken, the delay in force and
  // the number of counted samples since the last reset/delay change/flush.
  logic [N-1:0] hist [$];
  int           m_d;
  int           m_cnt;
  bit           m_init = 1'b0;

  always #5 clk = ~clk;

  delay_pipe #(.N(N), .MAXD(MAXD), .T(T), .Rval(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
`ifdef DELAY_PIPE_FLUSH_EN
    .flush   (flush),
`endif
    .dly_wr  (dly_wr),
    .dly     (dly),
    .dly_cur (dly_cur),
    .i       (i),
    .o       (o),
    .o_valid (o_valid)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit           ev;
    logic [N-1:0] eo;
    ev = (m_d == 0) || (m_cnt >= m_d);
    if (m_d == 0)  eo = i;
    else if (ev)   eo = hist[hist.size() - m_d];
    else           eo = '0;
    chk("dly_cur", dly_cur, m_d);
    chk("o_valid", o_valid, ev);
    chk("o",       o,       eo);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_init = 1'b1;
      m_d    = (T > MAXD) ? MAXD : T;
      m_cnt  = 0;
      hist.delete();
    end else begin
      if (en) begin
        hist.push_back(i);
        if (hist.size() > 2 * MAXD) void'(hist.pop_front());
      end
      if (dly_wr) begin
        m_d   = (int'(dly) > MAXD) ? MAXD : int'(dly);
        m_cnt = 0;
      end else if (flush) begin
        m_cnt = 0;
      end else if (en) begin
        m_cnt++;
      end
    end
  endtask

  // One clock: drive at negedge, check just after, then advance the model.
  task automatic cyc(input bit r, input bit e, input bit w, input int dv,
                     input bit f, input int data);
    @(negedge clk);
    rst    = r;
    en     = e;
    dly_wr = w;
    dly    = DW'(dv);
    flush  = f & HAS_FLUSH;
    i      = N'(data);
    #1;
    if (m_init) check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; dly_wr = 1'b0; dly = '0; flush = 1'b0; i = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Straight fill at the reset delay.
    for (k = 1; k <= 12; k++) cyc(0, 1, 0, 0, 0, k);

    // Alternating enable after a fresh reset.
    cyc(1, 0, 0, 0, 0, 0);
    for (k = 0; k < 20; k++) cyc(0, (k % 2) == 0, 0, 0, 0, 1 + k / 2);

    // Shrink delay mid-stream.
    for (k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 40 + k);
    cyc(0, 1, 1, 2, 0, 50);
    for (k = 51; k < 56; k++) cyc(0, 1, 0, 0, 0, k);

    // Oversized request saturates to MAXD; run across pointer wrap.
    cyc(0, 1, 1, 20, 0, 100);
    for (k = 0; k < 40; k++) cyc(0, 1, 0, 0, 0, $urandom_range(255, 0));

    // Zero delay bypass.
    cyc(0, 1, 1, 0, 0, 7);
    cyc(0, 1, 0, 0, 0, 8'hA5);
    for (k = 0; k < 6; k++) cyc(0, k % 2, 0, 0, 0, $urandom_range(255, 0));

    // Back to d=4, then reset colliding with dly_wr and en.
    cyc(0, 1, 1, 4, 0, 1);
    for (k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0, 10 + k);
    cyc(1, 1, 1, 7, 0, 99);
    for (k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 20 + k);

    // Flush at d=4 (a plain enabled cycle when the feature is absent).
    cyc(0, 1, 0, 0, 1, 30);
    for (k = 0; k < 8; k++) cyc(0, 1, 0, 0, 0, 31 + k);

    // Same-delay rewrite still re-masks.
    cyc(0, 1, 1, 4, 0, 60);
    for (k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 61 + k);

    // Random traffic.
    for (k = 0; k < 2000; k++) begin
      cyc($urandom_range(199, 0) == 0,
          $urandom_range(9, 0) < 7,
          $urandom_range(39, 0) == 0,
          $urandom_range(20, 0),
          $urandom_range(29, 0) == 0,
          $urandom_range(255, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
